// File: rtl/pin_test_pkg.sv
// Shared types and helpers for the pin-test pattern sequencer.
// Contents: the mode enum, the mode count, the default pin count and the
// pattern decode function.
package pin_test_pkg;

  localparam int unsigned NUM_MODES        = 4;
  localparam int unsigned DEFAULT_NUM_PINS = 26;
  localparam int unsigned MAX_PINS         = 32;

  typedef enum logic [1:0] {
    MODE_WALK1   = 2'd0,
    MODE_WALK0   = 2'd1,
    MODE_ALL_ON  = 2'd2,
    MODE_ALL_OFF = 2'd3
  } mode_e;

  // Full-width pattern for a given mode and pin position; callers truncate to their pin count.
  function automatic logic [MAX_PINS-1:0] pattern_decode(input mode_e m, input logic [4:0] idx);
    logic [MAX_PINS-1:0] onehot;
    onehot = MAX_PINS'(1) << idx;
    case (m)
      MODE_WALK1:   pattern_decode = onehot;
      MODE_WALK0:   pattern_decode = ~onehot;
      MODE_ALL_ON:  pattern_decode = '1;
      default:      pattern_decode = '0;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter and press detector.
// Ports:
//   clk      in  fabric clock
//   rst      in  synchronous active-high reset
//   btn_n_i  in  raw asynchronous button, active-low
//   press_o  out one-cycle pulse on each accepted press (debounced 1->0)
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q, db_q, db_dly_q, press_q;
  logic          db_d, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Accept a new level only after it has been stable for DEBOUNCE_CYCLES samples.
  always_comb begin
    db_d    = db_q;
    cnt_d   = '0;
    press_d = db_dly_q & ~db_q;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      db_q     <= 1'b1;
      db_dly_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      s1_q     <= btn_n_i;
      s2_q     <= s1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/pin_test_sequencer.sv
// Pin-test pattern sequencer: walks a pin position with a programmable dwell,
// selects the output pattern by mode, advances mode on each button press and
// toggles a heartbeat LED once per completed sweep.
// Ports:
//   clk         in  fabric clock, rising edge
//   rst         in  synchronous active-high reset
//   btn_n       in  raw button, active-low
//   out_pins    out registered test pattern, bit 0 drives OUT_0
//   pin_idx     out current pin position (zero-extended)
//   mode        out current mode (WALK1, WALK0, ALL_ON, ALL_OFF)
//   sweep_done  out one-cycle pulse when pin_idx wraps
//   led         out heartbeat, toggles on every sweep_done
module pin_test_sequencer
  import pin_test_pkg::*;
#(
  parameter int unsigned NUM_PINS        = DEFAULT_NUM_PINS,
  parameter int unsigned DWELL_CYCLES    = 4000000,
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_n,
  output logic [NUM_PINS-1:0] out_pins,
  output logic [4:0]          pin_idx,
  output logic [1:0]          mode,
  output logic                sweep_done,
  output logic                led
);

  localparam int unsigned   CW       = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned   PW       = $clog2(NUM_PINS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(NUM_PINS - 1);

  logic                press;
  mode_e               mode_q, mode_d;
  logic [PW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                sweep_q, sweep_d;
  logic                led_q, led_d;
  logic [NUM_PINS-1:0] out_q, out_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i (btn_n),
    .press_o (press)
  );

  // Press restarts the sweep and outranks a coincident dwell terminal.
  always_comb begin
    mode_d  = mode_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sweep_d = 1'b0;
    led_d   = led_q;
    if (press) begin
      mode_d = mode_e'(mode_q + 2'd1);
      idx_d  = '0;
      cnt_d  = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d   = '0;
        sweep_d = 1'b1;
        led_d   = ~led_q;
      end else begin
        idx_d = idx_q + PW'(1);
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    // Decoded from next state so the pattern lines up with mode/pin_idx.
    out_d = NUM_PINS'(pattern_decode(mode_d, 5'(idx_d)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_WALK1;
      idx_q   <= '0;
      cnt_q   <= '0;
      sweep_q <= 1'b0;
      led_q   <= 1'b0;
      out_q   <= NUM_PINS'(1);
    end else begin
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sweep_q <= sweep_d;
      led_q   <= led_d;
      out_q   <= out_d;
    end
  end

  assign out_pins   = out_q;
  assign pin_idx    = 5'(idx_q);
  assign mode       = mode_q;
  assign sweep_done = sweep_q;
  assign led        = led_q;

endmodule
